// File: rtl/free_list_ctrl.sv
// rtl/free_list_ctrl.sv - physical register free list with branch checkpoints
// Circular list of free pregs; head/tail carry an extra wrap bit so full and empty differ.
module free_list_ctrl #(
  parameter int NUM_ENTRIES = 32,
  parameter int PHY_REG_W   = 6,
  parameter int NUM_CKPT    = 4,
  localparam int PTR_W      = $clog2(NUM_ENTRIES),
  localparam int CK_W       = $clog2(NUM_CKPT)
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 alloc_req_i,
  output logic                 alloc_ready_o,
  output logic [PHY_REG_W-1:0] alloc_preg_o,
  input  logic                 free_valid_i,
  input  logic [PHY_REG_W-1:0] free_preg_i,
  input  logic                 ckpt_take_i,
  output logic [CK_W-1:0]      ckpt_id_o,
  output logic                 ckpt_full_o,
  input  logic                 ckpt_delete_i,
  input  logic                 recover_i,
  input  logic [CK_W-1:0]      recover_id_i,
  output logic [PTR_W-1:0]     head_o,
  output logic [PTR_W-1:0]     tail_o,
  output logic [PTR_W:0]       num_o
);

  localparam logic [PTR_W:0] FULL_NUM = (PTR_W+1)'(NUM_ENTRIES);
  localparam logic [PTR_W:0] PTR_ONE  = (PTR_W+1)'(1);
  localparam logic [CK_W-1:0] CK_ONE  = CK_W'(1);

  logic [PHY_REG_W-1:0] entry [NUM_ENTRIES];
  logic [PTR_W:0]       ckpt_head [NUM_CKPT];
  logic [PTR_W:0]       head_ext, tail_ext, num, head_nxt;
  logic [CK_W-1:0]      ckpt_wr, ckpt_rd, rec_rel;
  logic [CK_W:0]        ckpt_cnt;
  logic                 alloc_go, free_go, take_go, del_go;

  assign num      = tail_ext - head_ext;
  assign alloc_go = alloc_req_i && (num != '0) && !recover_i;
  // A full list can only absorb a free when an allocation leaves the same cycle.
  assign free_go  = free_valid_i && (free_preg_i != '0) && ((num != FULL_NUM) || alloc_go);
  assign take_go  = ckpt_take_i && !ckpt_full_o && !recover_i;
  assign del_go   = ckpt_delete_i && (ckpt_cnt != '0) && !recover_i;
  assign head_nxt = alloc_go ? head_ext + PTR_ONE : head_ext;
  assign rec_rel  = recover_id_i - ckpt_rd;

  assign alloc_ready_o = (num != '0);
  assign alloc_preg_o  = entry[head_ext[PTR_W-1:0]];
  assign head_o        = head_ext[PTR_W-1:0];
  assign tail_o        = tail_ext[PTR_W-1:0];
  assign num_o         = num;
  assign ckpt_id_o     = ckpt_wr;
  assign ckpt_full_o   = (ckpt_cnt == (CK_W+1)'(NUM_CKPT));

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < NUM_ENTRIES; i++) entry[i] <= PHY_REG_W'(NUM_ENTRIES + i);
      for (int i = 0; i < NUM_CKPT; i++) ckpt_head[i] <= '0;
      head_ext <= '0;
      tail_ext <= FULL_NUM;
      ckpt_wr  <= '0;
      ckpt_rd  <= '0;
      ckpt_cnt <= '0;
    end else begin
      if (free_go) begin
        entry[tail_ext[PTR_W-1:0]] <= free_preg_i;
        tail_ext <= tail_ext + PTR_ONE;
      end
      if (recover_i) begin
        // Restored checkpoint and every younger one are dropped.
        head_ext <= ckpt_head[recover_id_i];
        ckpt_wr  <= recover_id_i;
        ckpt_cnt <= {1'b0, rec_rel};
      end else begin
        head_ext <= head_nxt;
        if (take_go) begin
          ckpt_head[ckpt_wr] <= head_nxt;
          ckpt_wr <= ckpt_wr + CK_ONE;
        end
        if (del_go) ckpt_rd <= ckpt_rd + CK_ONE;
        ckpt_cnt <= ckpt_cnt + (CK_W+1)'(take_go) - (CK_W+1)'(del_go);
      end
    end
  end

  always @(posedge clk_i) begin
    if (rstn_i) begin
      assert (!(free_valid_i && (free_preg_i != '0) && !free_go));
      assert (!(ckpt_take_i && ckpt_full_o && !recover_i));
      assert (!recover_i || ({1'b0, rec_rel} < ckpt_cnt));
    end
  end

endmodule

// File: tb/tb_free_list_ctrl.sv
// tb/tb_free_list_ctrl.sv - bench for free_list_ctrl
// Reference keeps the list as an unbounded array indexed by absolute head/tail counts.
module tb_free_list_ctrl;
  localparam int N = 32;
  localparam int NC = 4;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       alloc_req = 1'b0, free_valid = 1'b0, ckpt_take = 1'b0;
  logic       ckpt_delete = 1'b0, recover = 1'b0;
  logic [5:0] free_preg = '0;
  logic [1:0] recover_id = '0;
  logic       alloc_ready, ckpt_full;
  logic [5:0] alloc_preg;
  logic [1:0] ckpt_id;
  logic [4:0] head, tail;
  logic [5:0] num;

  free_list_ctrl dut (
    .clk_i(clk), .rstn_i(rstn),
    .alloc_req_i(alloc_req), .alloc_ready_o(alloc_ready), .alloc_preg_o(alloc_preg),
    .free_valid_i(free_valid), .free_preg_i(free_preg),
    .ckpt_take_i(ckpt_take), .ckpt_id_o(ckpt_id), .ckpt_full_o(ckpt_full),
    .ckpt_delete_i(ckpt_delete), .recover_i(recover), .recover_id_i(recover_id),
    .head_o(head), .tail_o(tail), .num_o(num)
  );

  always #5 clk = ~clk;

  typedef struct {int id; int h;} ck_t;
  ck_t ckq[$];
  int  fifo [int];
  int  m_head, m_tail, m_next_id;
  int  vectors = 0, miscompares = 0;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    fifo.delete();
    for (int i = 0; i < N; i++) fifo[i] = N + i;
    m_head = 0;
    m_tail = N;
    m_next_id = 0;
    ckq.delete();
  endfunction

  function automatic void model_step(input bit a, input bit fv, input int fp, input bit tk,
                                     input bit dl, input bit rc, input int rid);
    int num_m, sz, k;
    bit ag, fg, full_pre;
    ck_t c;
    num_m = m_tail - m_head;
    sz = ckq.size();
    full_pre = (sz == NC);
    ag = a && num_m != 0 && !rc;
    fg = fv && fp != 0 && (num_m != N || ag);
    if (rc) begin
      k = -1;
      for (int i = 0; i < sz; i++) if (ckq[i].id == rid) k = i;
      if (k >= 0) begin
        m_head = ckq[k].h;
        while (ckq.size() > k) void'(ckq.pop_back());
        m_next_id = rid;
      end
    end else begin
      m_head = m_head + (ag ? 1 : 0);
      if (dl && sz > 0) void'(ckq.pop_front());
      if (tk && !full_pre) begin
        c.id = m_next_id;
        c.h = m_head;
        ckq.push_back(c);
        m_next_id = (m_next_id + 1) % NC;
      end
    end
    if (fg) begin
      fifo[m_tail] = fp;
      m_tail++;
    end
  endfunction

  task automatic check_all();
    chk("alloc_ready", int'(alloc_ready), (m_tail != m_head) ? 1 : 0);
    if (m_tail != m_head) chk("alloc_preg", int'(alloc_preg), fifo[m_head]);
    chk("head", int'(head), m_head % N);
    chk("tail", int'(tail), m_tail % N);
    chk("num", int'(num), m_tail - m_head);
    chk("ckpt_id", int'(ckpt_id), m_next_id);
    chk("ckpt_full", int'(ckpt_full), (ckq.size() == NC) ? 1 : 0);
  endtask

  task automatic cycle(input bit a, input bit fv, input int fp, input bit tk,
                       input bit dl, input bit rc, input int rid);
    alloc_req = a;
    free_valid = fv;
    free_preg = 6'(fp);
    ckpt_take = tk;
    ckpt_delete = dl;
    recover = rc;
    recover_id = 2'(rid);
    model_step(a, fv, fp, tk, dl, rc, rid);
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    alloc_req = 0; free_valid = 0; free_preg = '0; ckpt_take = 0;
    ckpt_delete = 0; recover = 0; recover_id = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    chk("rst_alloc_ready", int'(alloc_ready), 1);
    chk("rst_alloc_preg", int'(alloc_preg), 32);
    chk("rst_head", int'(head), 0);
    chk("rst_tail", int'(tail), 0);
    chk("rst_num", int'(num), 32);
    chk("rst_ckpt_id", int'(ckpt_id), 0);
    chk("rst_ckpt_full", int'(ckpt_full), 0);
    check_all();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit a, fv, tk, dl, rc;
    int fp, rid, k, hn, minref, first, last, nm;

    // Drain the whole list, then over-allocate and free into the empty list.
    do_reset();
    for (int i = 0; i < N; i++) begin
      chk("drain_preg", int'(alloc_preg), 32 + i);
      cycle(1, 0, 0, 0, 0, 0, 0);
    end
    chk("drain_num", int'(num), 0);
    chk("drain_ready", int'(alloc_ready), 0);
    chk("drain_head", int'(head), 0);
    cycle(1, 0, 0, 0, 0, 0, 0);
    chk("empty_alloc_head", int'(head), 0);
    chk("empty_alloc_num", int'(num), 0);
    cycle(1, 1, 40, 0, 0, 0, 0);
    chk("nobypass_head", int'(head), 0);
    chk("nobypass_num", int'(num), 1);
    chk("nobypass_preg", int'(alloc_preg), 40);

    // Full list with simultaneous alloc and free, then a free of p0.
    do_reset();
    cycle(1, 1, 63, 0, 0, 0, 0);
    chk("full_af_num", int'(num), 32);
    chk("full_af_head", int'(head), 1);
    chk("full_af_tail", int'(tail), 1);
    cycle(1, 0, 0, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0, 0);
    chk("p0_tail", int'(tail), 1);
    chk("p0_num", int'(num), 31);

    // Checkpoint taken alongside an alloc, then recovered.
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 1, 0, 0, 0);
    chk("take_id", int'(ckpt_id), 1);
    for (int i = 0; i < 5; i++) cycle(1, 0, 0, 0, 0, 0, 0);
    chk("pre_rec_head", int'(head), 9);
    cycle(0, 0, 0, 0, 0, 1, 0);
    chk("rec_head", int'(head), 4);
    chk("rec_num", int'(num), 28);
    chk("rec_id", int'(ckpt_id), 0);

    // Fill checkpoints, delete the oldest, recover a middle one with a free.
    do_reset();
    for (int i = 0; i < NC; i++) cycle(1, 0, 0, 1, 0, 0, 0);
    chk("ck_full", int'(ckpt_full), 1);
    chk("ck_full_id", int'(ckpt_id), 0);
    cycle(0, 0, 0, 0, 1, 0, 0);
    chk("ck_del_full", int'(ckpt_full), 0);
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 0, 0, 0);
    cycle(0, 1, 50, 0, 0, 1, 2);
    chk("ck_rec_head", int'(head), 3);
    chk("ck_rec_tail", int'(tail), 1);
    chk("ck_rec_num", int'(num), 30);
    chk("ck_rec_id", int'(ckpt_id), 2);
    chk("ck_rec_full", int'(ckpt_full), 0);
    cycle(0, 0, 0, 1, 0, 0, 0);
    cycle(0, 0, 0, 1, 0, 0, 0);
    chk("ck_refill_full2", int'(ckpt_full), 0);
    cycle(0, 0, 0, 1, 0, 0, 0);
    chk("ck_refill_full3", int'(ckpt_full), 1);
    chk("ck_refill_id", int'(ckpt_id), 1);

    // Random legal traffic, with a reset dropped in mid-stream.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) do_reset();
      a  = ($urandom_range(99) < 60);
      rc = (ckq.size() > 0) && ($urandom_range(99) < 8);
      k  = rc ? int'($urandom_range(ckq.size() - 1)) : 0;
      rid = rc ? ckq[k].id : int'($urandom_range(3));
      tk = (ckq.size() < NC) && ($urandom_range(99) < 20);
      dl = ($urandom_range(99) < 15);
      nm = m_tail - m_head;
      hn = rc ? ckq[k].h : m_head + ((a && nm != 0) ? 1 : 0);
      first = (!rc && dl && ckq.size() > 0) ? 1 : 0;
      last = rc ? k - 1 : ckq.size() - 1;
      minref = hn;
      for (int i = first; i <= last; i++) if (ckq[i].h < minref) minref = ckq[i].h;
      fp = ($urandom_range(19) == 0) ? 0 : int'($urandom_range(63, 1));
      fv = ($urandom_range(99) < 50) &&
           (fp == 0 || ((nm != N || (a && !rc)) && (m_tail + 1 - minref <= N)));
      cycle(a, fv, fp, tk, dl, rc, rid);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
